// File: rtl/bus_timer_device.sv
// Memory-mapped 64-bit timer: prescaled MTIME counter, 64-bit compare with optional
// auto-reload, level interrupt, and a shadowed high word for tear-free 64-bit reads.
module bus_timer_device #(
    parameter int          DataWidth     = 32,
    parameter int          AddressWidth  = 32,
    parameter logic [15:0] ResetPrescale = 16'd0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    device_req_i,
    input  logic                    device_we_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    irq_o
);

    localparam logic [2:0] AddrCtrl     = 3'd0;
    localparam logic [2:0] AddrPrescale = 3'd1;
    localparam logic [2:0] AddrMtimeLo  = 3'd2;
    localparam logic [2:0] AddrMtimeHi  = 3'd3;
    localparam logic [2:0] AddrCmpLo    = 3'd4;
    localparam logic [2:0] AddrCmpHi    = 3'd5;
    localparam logic [2:0] AddrStatus   = 3'd6;

    logic [2:0]           r_ctrl;
    logic [15:0]          r_prescale;
    logic [15:0]          r_pre_cnt;
    logic [63:0]          r_mtime;
    logic [63:0]          r_cmp;
    logic                 r_pending;
    logic [31:0]          r_shadow_hi;
    logic [DataWidth-1:0] r_rdata;

    logic [2:0]           w_sel;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_tick;
    logic                 w_match;
    logic                 w_lo_wr;
    logic                 w_carry;
    logic [32:0]          w_lo_inc;
    logic [31:0]          w_mtime_lo_n;
    logic [31:0]          w_mtime_hi_n;
    logic [DataWidth-1:0] w_rd_data;
    logic                 w_unused_addr;

    // Access protocol: device_req_i is a one-cycle strobe with no backpressure; a write
    // commits at the edge ending the request cycle, a read lands in device_rdata_o at
    // that same edge and holds until the next read.
    assign w_sel   = device_addr_i[4:2];
    assign w_wr    = device_req_i & device_we_i;
    assign w_rd    = device_req_i & ~device_we_i;
    assign w_lo_wr = w_wr && (w_sel == AddrMtimeLo);

    assign w_unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

    assign w_tick   = r_ctrl[0] && (r_pre_cnt == r_prescale);
    assign w_match  = (r_mtime == r_cmp);
    assign w_lo_inc = {1'b0, r_mtime[31:0]} + 33'd1;
    // A software write to the low word replaces the increment, so no carry propagates.
    assign w_carry  = w_lo_inc[32] & ~w_lo_wr;

    always_comb begin
        w_mtime_lo_n = r_mtime[31:0];
        w_mtime_hi_n = r_mtime[63:32];
        if (w_tick) begin
            if (w_match && r_ctrl[1]) begin
                w_mtime_lo_n = 32'd0;
                w_mtime_hi_n = 32'd0;
            end else begin
                w_mtime_lo_n = w_lo_inc[31:0];
                w_mtime_hi_n = r_mtime[63:32] + {31'd0, w_carry};
            end
        end
        if (w_lo_wr) begin
            w_mtime_lo_n = device_wdata_i;
        end
        if (w_wr && (w_sel == AddrMtimeHi)) begin
            w_mtime_hi_n = device_wdata_i;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            AddrCtrl:     w_rd_data = {29'd0, r_ctrl};
            AddrPrescale: w_rd_data = {16'd0, r_prescale};
            AddrMtimeLo:  w_rd_data = r_mtime[31:0];
            AddrMtimeHi:  w_rd_data = r_shadow_hi;
            AddrCmpLo:    w_rd_data = r_cmp[31:0];
            AddrCmpHi:    w_rd_data = r_cmp[63:32];
            AddrStatus:   w_rd_data = {31'd0, r_pending};
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl      <= 3'd0;
            r_prescale  <= ResetPrescale;
            r_pre_cnt   <= 16'd0;
            r_mtime     <= 64'd0;
            r_cmp       <= '1;
            r_pending   <= 1'b0;
            r_shadow_hi <= 32'd0;
            r_rdata     <= '0;
        end else begin
            if (w_wr) begin
                case (w_sel)
                    AddrCtrl:     r_ctrl        <= device_wdata_i[2:0];
                    AddrPrescale: r_prescale    <= device_wdata_i[15:0];
                    AddrCmpLo:    r_cmp[31:0]   <= device_wdata_i;
                    AddrCmpHi:    r_cmp[63:32]  <= device_wdata_i;
                    default:      ;
                endcase
            end

            r_mtime <= {w_mtime_hi_n, w_mtime_lo_n};

            if (!r_ctrl[0] || w_tick || (w_wr && (w_sel == AddrPrescale))) begin
                r_pre_cnt <= 16'd0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 16'd1;
            end

            // A match on the same edge as a clear keeps the interrupt pending.
            if (w_tick && w_match) begin
                r_pending <= 1'b1;
            end else if (w_wr && (w_sel == AddrStatus) && device_wdata_i[0]) begin
                r_pending <= 1'b0;
            end

            if (w_rd) begin
                r_rdata <= w_rd_data;
                if (w_sel == AddrMtimeLo) begin
                    r_shadow_hi <= r_mtime[63:32];
                end
            end
        end
    end

    assign device_rdata_o = r_rdata;
    assign irq_o          = r_pending & r_ctrl[2];

endmodule
